// File: rtl/text_banner_ctrl_if.sv
// text_banner_ctrl_if: control requests, pixel coordinates and glyph-renderer
// outputs shared by the banner controller and its neighbours.
`default_nettype none

interface text_banner_ctrl_if;
  logic        frame_tick;
  logic        show_req;
  logic [1:0]  msg_sel;
  logic        cancel;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [4:0]  char_code;
  logic [31:0] start_x;
  logic [31:0] start_y;
  logic        active;
  logic        busy;
  logic        done;

  modport slave (
    input  frame_tick, show_req, msg_sel, cancel, x, y,
    output char_code, start_x, start_y, active, busy, done
  );

  modport master (
    output frame_tick, show_req, msg_sel, cancel, x, y,
    input  char_code, start_x, start_y, active, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/text_banner_ctrl.sv
// text_banner_ctrl: message ROM plus reveal/blink sequencer driving a shared
// glyph renderer with a registered per-pixel slot/char/active path.
`default_nettype none

module text_banner_ctrl #(
  parameter int BANNER_X      = 192,
  parameter int BANNER_Y      = 220,
  parameter int CHAR_PITCH    = 32,
  parameter int MAX_LEN       = 8,
  parameter int REVEAL_FRAMES = 6,
  parameter int BLINK_FRAMES  = 30,
  parameter int HOLD_BLINKS   = 4
) (
  input  logic               clk,
  input  logic               reset,
  text_banner_ctrl_if.slave  bus
);

  localparam int SHIFT = $clog2(CHAR_PITCH);
  localparam int RW    = $clog2(MAX_LEN + 1);
  localparam int FMAX  = (REVEAL_FRAMES > BLINK_FRAMES) ? REVEAL_FRAMES : BLINK_FRAMES;
  localparam int FW    = $clog2(FMAX + 1);
  localparam int TW    = $clog2(2 * HOLD_BLINKS + 1);

  // Glyph codes: 0 blank, 1..26 = A..Z, 27 = '1', 28 = '2'
  localparam logic [4:0] MSG_ROM [0:3][0:7] = '{
    '{5'd16, 5'd27, 5'd0, 5'd23, 5'd9,  5'd14, 5'd19, 5'd0},
    '{5'd16, 5'd28, 5'd0, 5'd23, 5'd9,  5'd14, 5'd19, 5'd0},
    '{5'd18, 5'd5,  5'd1, 5'd4,  5'd25, 5'd0,  5'd0,  5'd0},
    '{5'd16, 5'd1,  5'd21, 5'd19, 5'd5, 5'd0,  5'd0,  5'd0}
  };

  typedef enum logic [1:0] {S_IDLE, S_REVEAL, S_HOLD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      msg_q, msg_d;
  logic [RW-1:0]   reveal_cnt_q, reveal_cnt_d, msg_len;
  logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TW-1:0]   toggle_cnt_q, toggle_cnt_d;
  logic            blink_on_q, blink_on_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            active_q, active_d;
  logic [4:0]      char_code_q, char_code_d;
  logic [31:0]     start_x_q, start_x_d;

  logic [10:0]     dx, slot;
  logic            in_band;

  assign msg_len = msg_q[1] ? RW'(5) : RW'(7);

  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    toggle_cnt_d = toggle_cnt_q;
    blink_on_d   = blink_on_q;

    case (state_q)
      S_IDLE: begin
        if (bus.show_req) begin
          msg_d        = bus.msg_sel;
          reveal_cnt_d = '0;
          frame_cnt_d  = '0;
          state_d      = S_REVEAL;
        end
      end
      S_REVEAL: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q == FW'(REVEAL_FRAMES - 1)) begin
            frame_cnt_d  = '0;
            reveal_cnt_d = reveal_cnt_q + 1'b1;
            if (reveal_cnt_d == msg_len) begin
              state_d      = S_HOLD;
              blink_on_d   = 1'b1;
              toggle_cnt_d = '0;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.frame_tick) begin
          if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d  = '0;
            blink_on_d   = ~blink_on_q;
            toggle_cnt_d = toggle_cnt_q + 1'b1;
            if (toggle_cnt_d == TW'(2 * HOLD_BLINKS))
              state_d = S_DONE;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        reveal_cnt_d = '0;
        state_d      = S_IDLE;
      end
    endcase

    // cancel overrides everything, including a same-cycle show_req
    if (bus.cancel) begin
      state_d      = S_IDLE;
      reveal_cnt_d = '0;
      frame_cnt_d  = '0;
      toggle_cnt_d = '0;
      blink_on_d   = 1'b1;
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    dx          = {1'b0, bus.x} - 11'(BANNER_X);
    slot        = dx >> SHIFT;
    in_band     = ({1'b0, bus.x} >= 11'(BANNER_X)) && (slot < 11'(MAX_LEN)) &&
                  ({1'b0, bus.y} >= 11'(BANNER_Y)) && ({1'b0, bus.y} < 11'(BANNER_Y + 40));
    start_x_d   = 32'(BANNER_X) + (32'(slot) << SHIFT);
    char_code_d = 5'd0;
    if (in_band && (slot < 11'd8))
      char_code_d = MSG_ROM[msg_q][slot[2:0]];
    active_d    = in_band && (slot < 11'(reveal_cnt_q)) && (char_code_d != 5'd0) &&
                  blink_on_q && ((state_q == S_REVEAL) || (state_q == S_HOLD)) &&
                  !bus.cancel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      msg_q        <= 2'd0;
      reveal_cnt_q <= '0;
      frame_cnt_q  <= '0;
      toggle_cnt_q <= '0;
      blink_on_q   <= 1'b1;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      active_q     <= 1'b0;
      char_code_q  <= 5'd0;
      start_x_q    <= 32'(BANNER_X);
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      reveal_cnt_q <= reveal_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      toggle_cnt_q <= toggle_cnt_d;
      blink_on_q   <= blink_on_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      active_q     <= active_d;
      char_code_q  <= char_code_d;
      start_x_q    <= start_x_d;
    end
  end

  assign bus.char_code = char_code_q;
  assign bus.start_x   = start_x_q;
  assign bus.start_y   = 32'(BANNER_Y);
  assign bus.active    = active_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: doc/text_banner_ctrl.md
Name: text_banner_ctrl

Overview:
- Sequences the on-screen text banner ("P1 WINS", "P2 WINS", "READY", "PAUSE") for the pong display.
- Holds a message ROM and a reveal/blink state machine, advanced by the per-frame tick.
- Drives one shared glyph renderer (start_x, start_y, char_code) per pixel, and gates its output with an active flag.
- Sits between the game FSM (show/cancel requests) and the VGA pixel mux.

Parameters:
- BANNER_X, 192, x pixel of the left edge of slot 0
- BANNER_Y, 220, y pixel of the top edge of every glyph
- CHAR_PITCH, 32, horizontal slot pitch in pixels; must be a power of 2 and at least 26
- MAX_LEN, 8, number of character slots
- REVEAL_FRAMES, 6, frames between successive character reveals; minimum 1
- BLINK_FRAMES, 30, frames per blink half-period in HOLD; minimum 1
- HOLD_BLINKS, 4, full on/off blink cycles before the banner clears

Ports:
- clk, input, 1, pixel clock
- reset, input, 1, asynchronous, active-high
- frame_tick, input, 1, one-cycle pulse per frame (start of vblank)
- show_req, input, 1, pulse that starts a message; honoured only in IDLE
- msg_sel, input, 2, message select, sampled with show_req
- cancel, input, 1, level; forces IDLE
- x, input, 10, current pixel x
- y, input, 10, current pixel y
- char_code, output, 5, glyph code for the current slot: 0 = blank, 1..26 = A..Z, 27 = '1', 28 = '2'
- start_x, output, 32, left edge of the current slot
- start_y, output, 32, top edge of the banner (always BANNER_Y)
- active, output, 1, the glyph output is to be shown at this pixel
- busy, output, 1, high in any state other than IDLE
- done, output, 1, one-cycle pulse when HOLD completes

Behaviour:
- Reset (async, active-high):
  - state = IDLE; all counters = 0; blink_on = 1.
  - active = 0, done = 0, busy = 0, char_code = 0, start_x = BANNER_X, start_y = BANNER_Y.
- Message ROM:
  - 0 = "P1 WINS"
  - 1 = "P2 WINS"
  - 2 = "READY"
  - 3 = "PAUSE"
  - Length msg_len is 7, 7, 5 and 5 respectively. Slots beyond msg_len read as blank.
- State machine:
  - IDLE: on show_req with cancel = 0, latch msg_sel, clear reveal_cnt and frame_cnt, go to REVEAL. If show_req and cancel arrive together, cancel wins and the state stays IDLE.
  - REVEAL: on each frame_tick, frame_cnt++. When frame_cnt = REVEAL_FRAMES-1 on a tick, frame_cnt = 0 and reveal_cnt++. If the new reveal_cnt equals msg_len, go to HOLD with frame_cnt = 0, blink_on = 1, toggle_cnt = 0.
  - HOLD: on each frame_tick, frame_cnt++. When frame_cnt = BLINK_FRAMES-1 on a tick, blink_on toggles, frame_cnt = 0 and toggle_cnt++. When toggle_cnt reaches 2*HOLD_BLINKS, go to DONE.
  - DONE: assert done for exactly one cycle, clear reveal_cnt, go to IDLE.
  - cancel in any state: next cycle the state is IDLE, counters are cleared, done is not asserted, active = 0.
  - show_req outside IDLE is ignored; msg_sel is held at its latched value.
- Pixel path (registered, 1-cycle latency from x/y to every pixel output):
  - dx = x - BANNER_X, computed with 11-bit width.
  - slot = dx >> log2(CHAR_PITCH).
  - in_band = (x >= BANNER_X) && (slot < MAX_LEN) && (y >= BANNER_Y) && (y < BANNER_Y+40).
  - start_x = BANNER_X + slot*CHAR_PITCH, zero-extended to 32 bits.
  - char_code = ROM[msg][slot] when in_band, else 0.
  - active = in_band && (slot < reveal_cnt) && (char_code != 0) && blink_on && (state is REVEAL or HOLD).
- Glyph renderer boundary: the glyph renderer checks the 26x40 cell, so pixels in the gap between cells yield no display even when active = 1.
- frame_tick while state = IDLE has no effect.

Test Plan:
- Reset mid-HOLD: all outputs return to reset values immediately; busy = 0.
- Reveal sequence: show_req with msg_sel = 2, REVEAL_FRAMES = 6. After 6 ticks reveal_cnt = 1. Pixel (x=200, y=230) gives active = 1, char_code = 18 ('R'), start_x = 192. Pixel at x=230 gives active = 0 until tick 12.
- Full cycle, msg_sel = 0: HOLD begins after 42 ticks. blink_on toggles every 30 ticks. done pulses once after 240 HOLD ticks; busy = 0 the following cycle.
- Blank slot: msg_sel = 0, slot 2 (x = 256..287) gives char_code = 0 and active = 0 at all times.
- Arbitration: show_req and cancel in the same cycle leave the state in IDLE. show_req during REVEAL with msg_sel = 3 does not change the message.
- Latency and bounds: x = 191 or y = 260 gives active = 0. A step of x from 223 to 224 changes start_x from 192 to 224 exactly one cycle later.
